usb_buf_arb: RTL and testbench

- Arbiter between the USB function core's buffer-memory port and a second host requester (DMA/CPU direct buffer access) sharing the single-port 32x16K buffer SRAM.
- Sits between the USB core, the host master and the SRAM macro inside the USB subsystem.
- USB core has absolute priority and zero added latency, because its SRAM interface cannot stall.
- The host side uses a req/ack handshake and is serviced in idle memory cycles.

---
 rtl/usb_buf_arb_pkg.sv | 17 +
 rtl/usb_buf_arb.sv | 183 ++++++++++++++++++
 tb/tb_usb_buf_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_buf_arb_pkg.sv
// Shared constants and FSM encoding for the USB buffer-memory arbiter.
// Optional build macro: USB_BUF_ARB_STAT_EN (host wait statistics).
package usb_buf_arb_pkg;

  localparam int unsigned USB_BUF_ARB_AW           = 14;
  localparam int unsigned USB_BUF_ARB_DW           = 32;
  localparam int unsigned USB_BUF_ARB_WCW          = 8;
  localparam int unsigned USB_BUF_ARB_STARVE_LIMIT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_RDATA = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_e;

endpackage : usb_buf_arb_pkg

// File: rtl/usb_buf_arb.sv
// Buffer SRAM arbiter: the USB core passes straight through; the host is served in idle cycles.
// Optional build macro: USB_BUF_ARB_STAT_EN adds hst_wait_max_o.
module usb_buf_arb
  import usb_buf_arb_pkg::*;
#(
  parameter int unsigned AW           = USB_BUF_ARB_AW,
  parameter int unsigned DW           = USB_BUF_ARB_DW,
  parameter int unsigned WCW          = USB_BUF_ARB_WCW,
  parameter int unsigned STARVE_LIMIT = USB_BUF_ARB_STARVE_LIMIT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [AW-1:0]  usb_adr_i,
  input  logic [DW-1:0]  usb_din_i,
  output logic [DW-1:0]  usb_dout_o,
  input  logic           usb_re_i,
  input  logic           usb_we_i,
  input  logic [AW-1:0]  hst_adr_i,
  input  logic [DW-1:0]  hst_dat_i,
  output logic [DW-1:0]  hst_dat_o,
  input  logic           hst_we_i,
  input  logic           hst_req_i,
  output logic           hst_ack_o,
  output logic [AW-1:0]  mem_addr_o,
  output logic [DW-1:0]  mem_wdata_o,
  input  logic [DW-1:0]  mem_rdata_i,
  output logic           mem_ren_o,
  output logic           mem_wen_o,
  output logic           starve_o,
`ifdef USB_BUF_ARB_STAT_EN
  output logic [WCW-1:0] hst_wait_max_o,
`endif
  input  logic           starve_clr_i
);

  localparam int unsigned WCNT_MAX = (2 ** WCW) - 1;

  arb_state_e     state_q, state_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [DW-1:0]  dat_q, dat_d;
  logic           we_q, we_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0]  hst_dat_q, hst_dat_d;
  logic           starve_q, starve_d;

  logic           usb_act;
  logic           hst_issue;
  logic           hst_ren;
  logic           hst_wen;
  logic           starve_set;
  logic [WCW-1:0] wcnt_inc;

  assign usb_act  = usb_re_i | usb_we_i;
  assign wcnt_inc = (wcnt_q == WCW'(WCNT_MAX)) ? wcnt_q : wcnt_q + WCW'(1);

  // Host FSM, wait counter and sticky starvation flag
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    wcnt_d     = wcnt_q;
    hst_dat_d  = hst_dat_q;
    starve_d   = starve_q;
    hst_issue  = 1'b0;
    hst_ren    = 1'b0;
    hst_wen    = 1'b0;
    starve_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hst_req_i) begin
          adr_d   = hst_adr_i;
          dat_d   = hst_dat_i;
          we_d    = hst_we_i;
          wcnt_d  = '0;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!usb_act) begin
          hst_issue = 1'b1;
          hst_wen   = we_q;
          hst_ren   = ~we_q;
          state_d   = we_q ? ST_ACK : ST_RDATA;
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == WCW'(STARVE_LIMIT)) begin
            starve_set = 1'b1;
          end
        end
      end
      ST_RDATA: begin
        hst_dat_d = mem_rdata_i;
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A simultaneous set beats the clear so a starvation event is never lost
    if (starve_clr_i) begin
      starve_d = 1'b0;
      wcnt_d   = '0;
    end
    if (starve_set) begin
      starve_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      wcnt_q    <= '0;
      hst_dat_q <= '0;
      starve_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      wcnt_q    <= wcnt_d;
      hst_dat_q <= hst_dat_d;
      starve_q  <= starve_d;
    end
  end

`ifdef USB_BUF_ARB_STAT_EN
  logic [WCW-1:0] wait_max_q, wait_max_d;

  // Track the worst wait observed when the host access finally issues
  always_comb begin
    wait_max_d = wait_max_q;
    if (hst_issue && (wcnt_q > wait_max_q)) begin
      wait_max_d = wcnt_q;
    end
    if (starve_clr_i) begin
      wait_max_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_max_q <= '0;
    end else begin
      wait_max_q <= wait_max_d;
    end
  end

  assign hst_wait_max_o = wait_max_q;
`endif

  // SRAM port mux: USB owns every cycle it is active, write beats read
  always_comb begin
    mem_addr_o  = adr_q;
    mem_wdata_o = dat_q;
    mem_wen_o   = hst_wen;
    mem_ren_o   = hst_ren;
    if (usb_act) begin
      mem_addr_o  = usb_adr_i;
      mem_wdata_o = usb_din_i;
      mem_wen_o   = usb_we_i;
      mem_ren_o   = usb_re_i & ~usb_we_i;
    end
    if (rst_i) begin
      mem_wen_o = 1'b0;
      mem_ren_o = 1'b0;
    end
  end

  assign usb_dout_o = mem_rdata_i;
  assign hst_dat_o  = hst_dat_q;
  assign hst_ack_o  = (state_q == ST_ACK);
  assign starve_o   = starve_q;

endmodule : usb_buf_arb

// File: tb/tb_usb_buf_arb.sv
// Directed self-checking bench for usb_buf_arb with a behavioural single-port SRAM.
// Optional build macro: USB_BUF_ARB_STAT_EN also checks hst_wait_max_o.
module tb_usb_buf_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [13:0] usb_adr_i;
  logic [31:0] usb_din_i;
  logic [31:0] usb_dout_o;
  logic        usb_re_i;
  logic        usb_we_i;
  logic [13:0] hst_adr_i;
  logic [31:0] hst_dat_i;
  logic [31:0] hst_dat_o;
  logic        hst_we_i;
  logic        hst_req_i;
  logic        hst_ack_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ren_o;
  logic        mem_wen_o;
  logic        starve_o;
  logic        starve_clr_i;
`ifdef USB_BUF_ARB_STAT_EN
  logic [7:0]  hst_wait_max_o;
`endif

  usb_buf_arb dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .usb_adr_i    (usb_adr_i),
    .usb_din_i    (usb_din_i),
    .usb_dout_o   (usb_dout_o),
    .usb_re_i     (usb_re_i),
    .usb_we_i     (usb_we_i),
    .hst_adr_i    (hst_adr_i),
    .hst_dat_i    (hst_dat_i),
    .hst_dat_o    (hst_dat_o),
    .hst_we_i     (hst_we_i),
    .hst_req_i    (hst_req_i),
    .hst_ack_o    (hst_ack_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ren_o    (mem_ren_o),
    .mem_wen_o    (mem_wen_o),
    .starve_o     (starve_o),
`ifdef USB_BUF_ARB_STAT_EN
    .hst_wait_max_o (hst_wait_max_o),
`endif
    .starve_clr_i (starve_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural SRAM: read data valid the cycle after mem_ren_o
  logic [31:0] mem [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[14'h0200] = 32'h0BAD_F00D;
    mem_rdata_i = 32'h0;
  end
  always @(posedge clk_i) begin
    if (mem_wen_o) mem[mem_addr_o] <= mem_wdata_o;
    if (mem_ren_o) mem_rdata_i <= mem[mem_addr_o];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [13:0] adr;
    logic [31:0] din;
    logic        exp_wen;
    logic        exp_ren;
    logic        chk_adr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{re:1'b1, we:1'b0, adr:14'h0001, din:32'h0000_0001, exp_wen:1'b0, exp_ren:1'b1, chk_adr:1'b1};
    vecs[1] = '{re:1'b0, we:1'b1, adr:14'h2AAA, din:32'hCAFE_F00D, exp_wen:1'b1, exp_ren:1'b0, chk_adr:1'b1};
    vecs[2] = '{re:1'b1, we:1'b1, adr:14'h3FFF, din:32'hA5A5_A5A5, exp_wen:1'b1, exp_ren:1'b0, chk_adr:1'b1};
    vecs[3] = '{re:1'b0, we:1'b0, adr:14'h1234, din:32'h1111_2222, exp_wen:1'b0, exp_ren:1'b0, chk_adr:1'b0};

    rst_i = 1'b1; usb_adr_i = '0; usb_din_i = '0; usb_re_i = 1'b1; usb_we_i = 1'b1;
    hst_adr_i = '0; hst_dat_i = '0; hst_we_i = 1'b0; hst_req_i = 1'b0; starve_clr_i = 1'b0;
    step(); settle();
    chk("rst_wen_forced", 32'(mem_wen_o), 32'h0);
    chk("rst_ren_forced", 32'(mem_ren_o), 32'h0);
    step(); step(); settle();
    chk("rst_hst_dat", hst_dat_o, 32'h0);
    chk("rst_ack", 32'(hst_ack_o), 32'h0);
    chk("rst_starve", 32'(starve_o), 32'h0);
`ifdef USB_BUF_ARB_STAT_EN
    chk("rst_wait_max", 32'(hst_wait_max_o), 32'h0);
`endif
    usb_re_i = 1'b0; usb_we_i = 1'b0;
    step();
    rst_i = 1'b0;

    // USB pass-through table, host idle
    for (int i = 0; i < 4; i++) begin
      step();
      usb_re_i = vecs[i].re; usb_we_i = vecs[i].we;
      usb_adr_i = vecs[i].adr; usb_din_i = vecs[i].din;
      settle();
      chk($sformatf("vec%0d_wen", i), 32'(mem_wen_o), 32'(vecs[i].exp_wen));
      chk($sformatf("vec%0d_ren", i), 32'(mem_ren_o), 32'(vecs[i].exp_ren));
      if (vecs[i].chk_adr) begin
        chk($sformatf("vec%0d_addr", i), 32'(mem_addr_o), 32'(vecs[i].adr));
        if (vecs[i].exp_wen) chk($sformatf("vec%0d_wdata", i), mem_wdata_o, vecs[i].din);
      end
    end
    step();
    usb_re_i = 1'b1; usb_we_i = 1'b0; usb_adr_i = 14'h2AAA;
    step();
    usb_re_i = 1'b0; settle();
    chk("usb_dout_rdlat", usb_dout_o, 32'hCAFE_F00D);

    // Host write, no contention: ack two cycles after the IDLE sample
    step();
    hst_req_i = 1'b1; hst_we_i = 1'b1; hst_adr_i = 14'h0123; hst_dat_i = 32'hDEAD_BEEF;
    settle();
    chk("wr_idle_no_wen", 32'(mem_wen_o), 32'h0);
    step();
    hst_req_i = 1'b0; hst_adr_i = 14'h0777; hst_dat_i = 32'h0;
    settle();
    chk("wr_pend_wen", 32'(mem_wen_o), 32'h1);
    chk("wr_pend_addr", 32'(mem_addr_o), 32'h0123);
    chk("wr_pend_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("wr_pend_ack", 32'(hst_ack_o), 32'h0);
    step(); settle();
    chk("wr_ack", 32'(hst_ack_o), 32'h1);
    chk("wr_ack_wen", 32'(mem_wen_o), 32'h0);

    // Host read back: ack and data three cycles after the IDLE sample
    step(); settle();
    chk("wr_ack_pulse", 32'(hst_ack_o), 32'h0);
    hst_req_i = 1'b1; hst_we_i = 1'b0; hst_adr_i = 14'h0123;
    step();
    hst_req_i = 1'b0; settle();
    chk("rd_pend_ren", 32'(mem_ren_o), 32'h1);
    chk("rd_pend_addr", 32'(mem_addr_o), 32'h0123);
    step(); settle();
    chk("rd_rdata_ack", 32'(hst_ack_o), 32'h0);
    step(); settle();
    chk("rd_ack", 32'(hst_ack_o), 32'h1);
    chk("rd_data", hst_dat_o, 32'hDEAD_BEEF);

    // USB read busy for 10 cycles while a host read is pending
    step();
    hst_req_i = 1'b1; hst_we_i = 1'b0; hst_adr_i = 14'h0200;
    settle();
    chk("ct_idle_ren", 32'(mem_ren_o), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) begin
        hst_req_i = 1'b0; usb_re_i = 1'b1; usb_adr_i = 14'h2AAA;
      end
      settle();
      chk($sformatf("ct_busy%0d_addr", k), 32'(mem_addr_o), 32'h2AAA);
      chk($sformatf("ct_busy%0d_ren", k), 32'(mem_ren_o), 32'h1);
      if (k >= 2) chk($sformatf("ct_busy%0d_dout", k), usb_dout_o, 32'hCAFE_F00D);
    end
    step();
    usb_re_i = 1'b0; settle();
    chk("ct_issue_ren", 32'(mem_ren_o), 32'h1);
    chk("ct_issue_addr", 32'(mem_addr_o), 32'h0200);
    chk("ct_issue_dout", usb_dout_o, 32'hCAFE_F00D);
    step(); settle();
    chk("ct_rdata_ack", 32'(hst_ack_o), 32'h0);
    step(); settle();
    chk("ct_ack", 32'(hst_ack_o), 32'h1);
    chk("ct_data", hst_dat_o, 32'h0BAD_F00D);
    chk("ct_no_starve", 32'(starve_o), 32'h0);

    // Starvation: USB writes 70 cycles while a host write waits
    step();
    hst_req_i = 1'b1; hst_we_i = 1'b1; hst_adr_i = 14'h0300; hst_dat_i = 32'h1234_5678;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i == 1) begin
        hst_req_i = 1'b0; usb_we_i = 1'b1; usb_adr_i = 14'h0400; usb_din_i = 32'h55;
      end
      settle();
      chk($sformatf("sv_starve_c%0d", i), 32'(starve_o), (i >= 65) ? 32'h1 : 32'h0);
      if (i == 1 || i == 70) chk($sformatf("sv_usbwr_c%0d", i), 32'(mem_addr_o), 32'h0400);
    end
    step();
    usb_we_i = 1'b0; settle();
    chk("sv_issue_wen", 32'(mem_wen_o), 32'h1);
    chk("sv_issue_addr", 32'(mem_addr_o), 32'h0300);
    chk("sv_issue_wdata", mem_wdata_o, 32'h1234_5678);
    step(); settle();
    chk("sv_ack", 32'(hst_ack_o), 32'h1);
    chk("sv_starve_sticky", 32'(starve_o), 32'h1);
    chk("sv_wr_keeps_dat", hst_dat_o, 32'h0BAD_F00D);
`ifdef USB_BUF_ARB_STAT_EN
    chk("sv_wait_max", 32'(hst_wait_max_o), 32'd70);
`endif
    step();
    starve_clr_i = 1'b1;
    step();
    starve_clr_i = 1'b0; settle();
    chk("sv_starve_clr", 32'(starve_o), 32'h0);
`ifdef USB_BUF_ARB_STAT_EN
    chk("sv_wait_max_clr", 32'(hst_wait_max_o), 32'h0);
`endif

    // Reset while in RDATA: no ack, read data cleared, enables forced low
    step();
    hst_req_i = 1'b1; hst_we_i = 1'b0; hst_adr_i = 14'h0123;
    step();
    hst_req_i = 1'b0; settle();
    chk("rr_pend_ren", 32'(mem_ren_o), 32'h1);
    step();
    rst_i = 1'b1; usb_re_i = 1'b1; usb_adr_i = 14'h0001; settle();
    chk("rr_rst_ren", 32'(mem_ren_o), 32'h0);
    chk("rr_rst_wen", 32'(mem_wen_o), 32'h0);
    step(); settle();
    chk("rr_no_ack", 32'(hst_ack_o), 32'h0);
    chk("rr_dat_zero", hst_dat_o, 32'h0);
    chk("rr_rst_ren2", 32'(mem_ren_o), 32'h0);
    rst_i = 1'b0; usb_re_i = 1'b0;
    step(); settle();
    chk("rr_no_ack2", 32'(hst_ack_o), 32'h0);
    hst_req_i = 1'b1; hst_we_i = 1'b1; hst_adr_i = 14'h3FFF; hst_dat_i = 32'h0F0F_0F0F;
    step();
    hst_req_i = 1'b0; settle();
    chk("rr_post_wen", 32'(mem_wen_o), 32'h1);
    chk("rr_post_addr", 32'(mem_addr_o), 32'h3FFF);
    step(); settle();
    chk("rr_post_ack", 32'(hst_ack_o), 32'h1);

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_usb_buf_arb
